// File: rtl/shift_writeback_stage.sv
// shift_writeback_stage
//
// Registered writeback stage that sits right after the right-shift block.
// Shift results are queued in a small in-order FIFO and handed to the
// register-file write port through a valid/ready handshake. The stage also
// keeps the C/Z/N status flags and feeds C back to the shifter carry-in.
//
// Ports
//   LOGISIM_CLOCK_TREE_0  clock bundle: [4] global clock, [2] tick enable
//   RESET                 asynchronous active-high reset
//   FLUSH                 synchronous buffer clear (flags untouched)
//   IN_VALID / IN_READY   upstream handshake
//   RESULT_IN, COUT_IN    shifter result and carry-out
//   DEST_REG              destination register index (0 = discard)
//   FLAG_EN               update C/Z/N with this result
//   WB_VALID / WB_READY   register-file handshake
//   WB_DATA, WB_ADDR      head entry (0 when the buffer is empty)
//   FLAG_C/Z/N            status flags
//   CIN_OUT               copy of FLAG_C for the shifter carry-in
module shift_writeback_stage #(
  parameter int NR_OF_BITS = 32,
  parameter int DEPTH      = 2
) (
  input  logic [4:0]            LOGISIM_CLOCK_TREE_0,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [NR_OF_BITS-1:0] RESULT_IN,
  input  logic                  COUT_IN,
  input  logic [4:0]            DEST_REG,
  input  logic                  FLAG_EN,
  output logic                  WB_VALID,
  input  logic                  WB_READY,
  output logic [NR_OF_BITS-1:0] WB_DATA,
  output logic [4:0]            WB_ADDR,
  output logic                  FLAG_C,
  output logic                  FLAG_Z,
  output logic                  FLAG_N,
  output logic                  CIN_OUT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic clk;
  logic tick;
  logic unused_tree_bits;

  logic [NR_OF_BITS-1:0] data_mem [DEPTH];
  logic [4:0]            addr_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic accept;
  logic push;
  logic pop;

  assign clk  = LOGISIM_CLOCK_TREE_0[4];
  assign tick = LOGISIM_CLOCK_TREE_0[2];
  assign unused_tree_bits = ^{LOGISIM_CLOCK_TREE_0[3], LOGISIM_CLOCK_TREE_0[1:0]};

  // Handshake decode. Both ready and valid are gated by tick so that no
  // transfer is ever reported on an edge where the registers hold.
  assign IN_READY = tick & ~RESET & ~FLUSH & (count < DEPTH_CNT);
  assign WB_VALID = tick & (count != '0);
  assign accept   = IN_VALID & IN_READY;
  // R0 is hardwired, so a result aimed at it only touches the flags.
  assign push     = accept & (DEST_REG != 5'd0);
  assign pop      = WB_VALID & WB_READY;

  // Head entry is forced to zero when empty so stale data never leaks out.
  assign WB_DATA = (count != '0) ? data_mem[rd_ptr] : '0;
  assign WB_ADDR = (count != '0) ? addr_mem[rd_ptr] : 5'd0;

  // Payload storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= RESULT_IN;
      addr_mem[wr_ptr] <= DEST_REG;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. FLUSH wins
  // over push and pop; push is already blocked by IN_READY during FLUSH.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (tick) begin
      if (FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Flags follow every accepted result with FLAG_EN, independent of whether
  // the result was buffered or discarded (DEST_REG = 0).
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      FLAG_C <= 1'b0;
      FLAG_Z <= 1'b0;
      FLAG_N <= 1'b0;
    end else if (accept && FLAG_EN) begin
      FLAG_C <= COUT_IN;
      FLAG_Z <= (RESULT_IN == '0);
      FLAG_N <= RESULT_IN[NR_OF_BITS-1];
    end
  end

  assign CIN_OUT = FLAG_C;

endmodule

// File: tb/tb_shift_writeback_stage.sv
// Testbench for shift_writeback_stage: table-driven vectors with a payload
// scoreboard, followed by a hand-written asynchronous reset sequence.
module tb_shift_writeback_stage;

  typedef struct {
    logic        tick;
    logic        in_valid;
    logic [31:0] result;
    logic        cout;
    logic [4:0]  dest;
    logic        flag_en;
    logic        wb_ready;
    logic        flush;
    logic        exp_in_ready;
    logic        exp_wb_valid;
    logic [2:0]  exp_czn;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
  } sb_t;

  logic        clk = 1'b0;
  logic        tick = 1'b1;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] result_in = '0;
  logic        cout_in = 1'b0;
  logic [4:0]  dest_reg = '0;
  logic        flag_en = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        flag_c, flag_z, flag_n, cin_out;
  logic [4:0]  clock_tree;

  int passed = 0;
  int total  = 0;

  vec_t vecs[$];
  sb_t  model_q[$];

  assign clock_tree = {clk, 1'b0, tick, 2'b00};

  always #5 clk = ~clk;

  shift_writeback_stage #(.NR_OF_BITS(32), .DEPTH(2)) dut (
    .LOGISIM_CLOCK_TREE_0(clock_tree),
    .RESET(rst),
    .FLUSH(flush),
    .IN_VALID(in_valid),
    .IN_READY(in_ready),
    .RESULT_IN(result_in),
    .COUT_IN(cout_in),
    .DEST_REG(dest_reg),
    .FLAG_EN(flag_en),
    .WB_VALID(wb_valid),
    .WB_READY(wb_ready),
    .WB_DATA(wb_data),
    .WB_ADDR(wb_addr),
    .FLAG_C(flag_c),
    .FLAG_Z(flag_z),
    .FLAG_N(flag_n),
    .CIN_OUT(cin_out)
  );

  function automatic vec_t mk(input logic t, input logic iv, input logic [31:0] r,
                              input logic c, input logic [4:0] d, input logic fe,
                              input logic wr, input logic fl, input logic eir,
                              input logic ewv, input logic [2:0] czn);
    vec_t v;
    v.tick = t; v.in_valid = iv; v.result = r; v.cout = c; v.dest = d;
    v.flag_en = fe; v.wb_ready = wr; v.flush = fl; v.exp_in_ready = eir;
    v.exp_wb_valid = ewv; v.exp_czn = czn;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    tick     = v.tick;
    in_valid = v.in_valid;
    result_in = v.result;
    cout_in  = v.cout;
    dest_reg = v.dest;
    flag_en  = v.flag_en;
    wb_ready = v.wb_ready;
    flush    = v.flush;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passed++;
  endtask

  task automatic checkFlags(input string name, input logic [2:0] czn);
    checkOutput({name, " flag_c"}, 32'(flag_c), 32'(czn[2]));
    checkOutput({name, " flag_z"}, 32'(flag_z), 32'(czn[1]));
    checkOutput({name, " flag_n"}, 32'(flag_n), 32'(czn[0]));
    checkOutput({name, " cin_out"}, 32'(cin_out), 32'(czn[2]));
  endtask

  initial begin
    // Columns: tick, in_valid, result, cout, dest, flag_en, wb_ready, flush,
    //          expected in_ready, expected wb_valid (both before the edge),
    //          expected {C,Z,N} after the edge.
    vecs.push_back(mk(1, 1, 32'h8000_0001, 1, 5'd3, 1, 1, 0, 1, 0, 3'b101));
    vecs.push_back(mk(1, 0, 32'h0,         0, 5'd0, 0, 1, 0, 1, 1, 3'b101));
    vecs.push_back(mk(1, 1, 32'h11,        0, 5'd1, 0, 0, 0, 1, 0, 3'b101));
    vecs.push_back(mk(1, 1, 32'h22,        0, 5'd2, 0, 0, 0, 1, 1, 3'b101));
    vecs.push_back(mk(1, 1, 32'h33,        0, 5'd3, 0, 0, 0, 0, 1, 3'b101));
    vecs.push_back(mk(1, 1, 32'h33,        0, 5'd3, 0, 1, 0, 0, 1, 3'b101));
    vecs.push_back(mk(1, 1, 32'h33,        0, 5'd3, 0, 1, 0, 1, 1, 3'b101));
    vecs.push_back(mk(1, 0, 32'h0,         0, 5'd0, 0, 1, 0, 1, 1, 3'b101));
    vecs.push_back(mk(1, 1, 32'h0,         0, 5'd0, 1, 1, 0, 1, 0, 3'b010));
    vecs.push_back(mk(1, 0, 32'h0,         0, 5'd0, 0, 1, 0, 1, 0, 3'b010));
    vecs.push_back(mk(1, 1, 32'h44,        1, 5'd4, 1, 0, 0, 1, 0, 3'b100));
    vecs.push_back(mk(1, 1, 32'h55,        0, 5'd5, 0, 0, 0, 1, 1, 3'b100));
    vecs.push_back(mk(1, 1, 32'h0,         0, 5'd6, 1, 0, 1, 0, 1, 3'b100));
    vecs.push_back(mk(1, 0, 32'h0,         0, 5'd0, 0, 1, 0, 1, 0, 3'b100));
    vecs.push_back(mk(0, 1, 32'h66,        0, 5'd7, 1, 1, 0, 0, 0, 3'b100));
    vecs.push_back(mk(0, 1, 32'h66,        0, 5'd7, 1, 1, 0, 0, 0, 3'b100));
    vecs.push_back(mk(0, 1, 32'h66,        0, 5'd7, 1, 1, 0, 0, 0, 3'b100));
    vecs.push_back(mk(1, 1, 32'h66,        0, 5'd7, 1, 1, 0, 1, 0, 3'b000));
    vecs.push_back(mk(1, 0, 32'h0,         0, 5'd0, 0, 1, 0, 1, 1, 3'b000));

    #3;
    checkOutput("reset in_ready", 32'(in_ready), 32'h0);
    checkOutput("reset wb_valid", 32'(wb_valid), 32'h0);
    checkOutput("reset wb_data", wb_data, 32'h0);
    checkOutput("reset wb_addr", 32'(wb_addr), 32'h0);
    checkFlags("reset", 3'b000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
      checkOutput($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].exp_wb_valid));
      if (model_q.size() > 0) begin
        checkOutput($sformatf("v%0d wb_data", i), wb_data, model_q[0].data);
        checkOutput($sformatf("v%0d wb_addr", i), 32'(wb_addr), 32'(model_q[0].addr));
      end else begin
        checkOutput($sformatf("v%0d wb_data empty", i), wb_data, 32'h0);
        checkOutput($sformatf("v%0d wb_addr empty", i), 32'(wb_addr), 32'h0);
      end
      if (vecs[i].tick && vecs[i].flush) begin
        model_q.delete();
      end else begin
        if (vecs[i].exp_wb_valid && vecs[i].wb_ready && model_q.size() > 0)
          void'(model_q.pop_front());
        if (vecs[i].exp_in_ready && vecs[i].in_valid && vecs[i].dest != 5'd0)
          model_q.push_back('{data: vecs[i].result, addr: vecs[i].dest});
      end
      @(posedge clk);
      #1;
      checkFlags($sformatf("v%0d", i), vecs[i].exp_czn);
    end

    // Asynchronous reset while one entry is stalled at the head.
    @(negedge clk);
    applyStimulus(mk(1, 1, 32'h77, 1, 5'd8, 1, 0, 0, 1, 0, 3'b100));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("pre-reset wb_valid", 32'(wb_valid), 32'h1);
    checkOutput("pre-reset wb_data", wb_data, 32'h77);
    checkFlags("pre-reset", 3'b100);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async reset wb_valid", 32'(wb_valid), 32'h0);
    checkOutput("async reset wb_data", wb_data, 32'h0);
    checkOutput("async reset wb_addr", 32'(wb_addr), 32'h0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'h0);
    checkFlags("async reset", 3'b000);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'h1);
    applyStimulus(mk(1, 1, 32'h99, 0, 5'd9, 0, 1, 0, 1, 0, 3'b000));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("post-reset wb_valid", 32'(wb_valid), 32'h1);
    checkOutput("post-reset wb_data", wb_data, 32'h99);
    checkOutput("post-reset wb_addr", 32'(wb_addr), 32'd9);
    @(posedge clk);
    #1;
    checkOutput("post-reset drained", 32'(wb_valid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
